// File: rtl/handshake_rr_arbiter.sv
// Three-input round-robin arbiter with valid/ready handshakes and a one-entry registered output stage.
// Optional embedded assertions: define HANDSHAKE_RR_ARBITER_ASSERT_EN.
module handshake_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             handshake_arr_0_valid,
  output logic             handshake_arr_0_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic             handshake_arr_1_valid,
  output logic             handshake_arr_1_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic             handshake_arr_2_valid,
  output logic             handshake_arr_2_ready,
  input  logic [WIDTH-1:0] in_2,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_id
);

  // Handshake rule on every port: a beat moves exactly at a rising CLK edge
  // where valid and ready are both 1; a valid beat is held stable until then.

  logic [1:0]       lg;
  logic [2:0]       valid_vec;
  logic [2:0]       grant;
  logic [2:0]       ready_vec;
  logic             space;
  logic [1:0]       sel;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] in_arr [3];

  assign valid_vec = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};
  assign in_arr[0] = in_0;
  assign in_arr[1] = in_1;
  assign in_arr[2] = in_2;
  assign space     = !handshake_valid || handshake_ready;

  // Search starts just after the last granted requester.
  always_comb begin
    grant = 3'b000;
    case (lg)
      2'd0: begin
        if (valid_vec[1])      grant = 3'b010;
        else if (valid_vec[2]) grant = 3'b100;
        else if (valid_vec[0]) grant = 3'b001;
      end
      2'd1: begin
        if (valid_vec[2])      grant = 3'b100;
        else if (valid_vec[0]) grant = 3'b001;
        else if (valid_vec[1]) grant = 3'b010;
      end
      default: begin
        if (valid_vec[0])      grant = 3'b001;
        else if (valid_vec[1]) grant = 3'b010;
        else if (valid_vec[2]) grant = 3'b100;
      end
    endcase
  end

  // Reset gates the readies so no beat is taken while the stage is being cleared.
  assign ready_vec = (space && !ASYNCRESET) ? grant : 3'b000;
  assign handshake_arr_0_ready = ready_vec[0];
  assign handshake_arr_1_ready = ready_vec[1];
  assign handshake_arr_2_ready = ready_vec[2];

  always_comb begin
    sel = 2'd0;
    if (ready_vec[1])      sel = 2'd1;
    else if (ready_vec[2]) sel = 2'd2;
    sel_data = in_arr[sel];
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      handshake_valid <= 1'b0;
      out             <= '0;
      out_id          <= 2'd0;
      lg              <= 2'd2;
    end else if (|ready_vec) begin
      handshake_valid <= 1'b1;
      out             <= sel_data;
      out_id          <= sel;
      lg              <= sel;
    end else if (handshake_ready) begin
      handshake_valid <= 1'b0;
    end
  end

`ifdef HANDSHAKE_RR_ARBITER_ASSERT_EN
  for (genvar k = 0; k < 3; k++) begin : g_up_chk
    a_up_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
      valid_vec[k] && !ready_vec[k] |=> valid_vec[k] && $stable(in_arr[k]));
  end

  a_out_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    handshake_valid && !handshake_ready |=> handshake_valid && $stable(out) && $stable(out_id));

  a_stall_no_ready: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    handshake_valid && !handshake_ready |-> ready_vec == 3'b000);

  a_ready_onehot0: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    $onehot0(ready_vec));

  a_out_id_range: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    out_id != 2'd3);
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Scoreboard bench for handshake_rr_arbiter: directed scenarios then random traffic
// against a priority-list reference model.
module tb_handshake_rr_arbiter;
  localparam int W = 4;

  logic          CLK = 1'b0;
  logic          ASYNCRESET;
  logic [2:0]    v;
  logic [W-1:0]  d [3];
  logic          hr;
  logic [2:0]    rdy;
  logic          handshake_valid;
  logic [W-1:0]  out;
  logic [1:0]    out_id;

  logic [W+1:0]  exp_q[$];
  int            checks;
  int            failures;
  int            m_lg;
  bit            m_vld;
  bit            acc [3];

  always #5 CLK = ~CLK;

  handshake_rr_arbiter #(.WIDTH(W)) dut (
    .CLK                   (CLK),
    .ASYNCRESET            (ASYNCRESET),
    .handshake_arr_0_valid (v[0]),
    .handshake_arr_0_ready (rdy[0]),
    .in_0                  (d[0]),
    .handshake_arr_1_valid (v[1]),
    .handshake_arr_1_ready (rdy[1]),
    .in_1                  (d[1]),
    .handshake_arr_2_valid (v[2]),
    .handshake_arr_2_ready (rdy[2]),
    .in_2                  (d[2]),
    .handshake_valid       (handshake_valid),
    .handshake_ready       (hr),
    .out                   (out),
    .out_id                (out_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Walk the requesters in order last+1, last+2, last+3 (mod 3).
  function automatic int pick(input int lg, input logic [2:0] vv);
    int k;
    for (int i = 1; i <= 3; i++) begin
      k = (lg + i) % 3;
      if (vv[k]) return k;
    end
    return -1;
  endfunction

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic step();
    int w;
    bit space;
    #1;
    chk("out_valid", handshake_valid, m_vld);
    space = !m_vld || hr;
    w = pick(m_lg, v);
    for (int k = 0; k < 3; k++) begin
      acc[k] = 1'b0;
      chk($sformatf("ready%0d", k), rdy[k], (space && w == k));
    end
    if (space && w >= 0) begin
      exp_q.push_back({2'(w), d[w]});
      m_lg   = w;
      m_vld  = 1'b1;
      acc[w] = 1'b1;
    end else if (hr) begin
      m_vld = 1'b0;
    end
    @(negedge CLK);
  endtask

  // Monitor: every downstream transfer must match the oldest expected beat.
  initial begin : monitor
    logic [W+1:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (!ASYNCRESET && handshake_valid && hr) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual_out=%0h actual_id=%0d expected=none", out, out_id);
        end else begin
          e = exp_q.pop_front();
          chk("out", out, e[W-1:0]);
          chk("out_id", out_id, e[W+1:W]);
        end
      end
    end
  end

  initial begin : stim
    checks     = 0;
    failures   = 0;
    ASYNCRESET = 1'b1;
    v          = 3'b000;
    hr         = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[k]   = '0;
      acc[k] = 1'b0;
    end
    m_lg  = 2;
    m_vld = 1'b0;

    // Reset state, with all requesters pushing
    #1;
    v  = 3'b111;
    hr = 1'b1;
    #1;
    chk("rst_valid", handshake_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_readies", rdy, 0);
    v  = 3'b000;
    hr = 1'b0;
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    // First beat right after release
    v[0] = 1'b1; d[0] = 4'hA; hr = 1'b1;
    step();
    chk("first_out", out, 4'hA);
    chk("first_out_id", out_id, 0);
    v = 3'b000;
    step();

    // All three valid: fair rotation
    v = 3'b111; d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; hr = 1'b1;
    repeat (6) step();
    v = 3'b000;
    step();

    // Downstream stall holds the entry and blocks all upstream readies
    v = 3'b001; d[0] = 4'h5; hr = 1'b0;
    step();
    v = 3'b110; d[1] = 4'h6; d[2] = 4'h7;
    repeat (4) begin
      step();
      chk("stall_out", out, 4'h5);
      chk("stall_out_id", out_id, 0);
    end
    hr = 1'b1;
    step();
    v = 3'b000;
    step();

    // Lone requester 2, then contention with 0
    v = 3'b100;
    for (int i = 0; i < 3; i++) begin
      d[2] = W'(7 + i);
      step();
    end
    v = 3'b101; d[0] = 4'hC; d[2] = 4'hD;
    step();
    v = 3'b000;
    step();

    // Asynchronous reset in the middle of a stalled cycle
    v = 3'b001; d[0] = 4'h3; hr = 1'b0;
    step();
    v = 3'b011; d[1] = 4'h9;
    #3;
    ASYNCRESET = 1'b1;
    #1;
    chk("async_rst_valid", handshake_valid, 0);
    chk("async_rst_out", out, 0);
    chk("async_rst_out_id", out_id, 0);
    chk("async_rst_readies", rdy, 0);
    exp_q.delete();
    m_vld = 1'b0;
    m_lg  = 2;
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    hr = 1'b1;
    step();
    v = 3'b000;
    step();

    // Random traffic; a requester keeps its beat until accepted
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) v[k] = 1'b0;
        if (!v[k] && $urandom_range(0, 99) < 60) begin
          v[k] = 1'b1;
          d[k] = W'($urandom_range(0, (1 << W) - 1));
        end
      end
      hr = ($urandom_range(0, 99) < 70);
      step();
    end

    v  = 3'b000;
    hr = 1'b1;
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, data payload width in bits per requester and output.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 ASYNCRESET  input  1  asynchronous, active-high reset.
REQ-004 handshake_arr_k_valid  input  1  requester k (k = 0,1,2) offers data.
REQ-005 handshake_arr_k_ready  output  1  arbiter accepts requester k this cycle.
REQ-006 in_k  input  WIDTH  payload of requester k (k = 0,1,2).
REQ-007 handshake_valid  output  1  output register holds a beat.
REQ-008 handshake_ready  input  1  downstream accepts the output beat.
REQ-009 out  output  WIDTH  payload of the held beat.
REQ-010 out_id  output  2  index (0..2) of the requester that supplied the held beat; value 3 is never driven.

Function
REQ-011 Transfer on any port SHALL occur exactly when valid and ready are both 1 at a rising CLK edge.
REQ-012 Output stage SHALL be a single registered entry; "space" = !handshake_valid || handshake_ready.
REQ-013 Grant SHALL be one-hot or zero, computed combinationally from the three valids and a 2-bit last-grant pointer LG.
REQ-014 Priority order SHALL be LG+1, LG+2, LG+3 (mod 3); the first valid requester in that order wins.
REQ-015 handshake_arr_k_ready SHALL equal grant_k && space; at most one upstream ready is high per cycle.
REQ-016 No upstream ready SHALL depend on any other requester's data; ready MAY depend on valids and handshake_ready.
REQ-017 On upstream transfer from k: out <= in_k, out_id <= k, handshake_valid <= 1, LG <= k, all at the same edge (latency 1 cycle).
REQ-018 On downstream transfer with no simultaneous upstream transfer: handshake_valid <= 0; out and out_id hold their values.
REQ-019 Simultaneous downstream and upstream transfer SHALL replace the entry with the new beat (sustained throughput 1 beat/cycle).
REQ-020 While handshake_valid && !handshake_ready, out, out_id and handshake_valid SHALL remain stable and all upstream readies SHALL be 0.
REQ-021 LG SHALL change only on an upstream transfer; idle cycles and stalled cycles SHALL NOT rotate priority.
REQ-022 With all three requesters continuously valid and downstream always ready, grants SHALL cycle 0,1,2,0,... with no requester served twice before the others.
REQ-023 A single valid requester SHALL be granted every cycle space exists, regardless of LG.

Reset
REQ-024 While ASYNCRESET = 1: handshake_valid = 0, out = 0, out_id = 0, LG = 2 (requester 0 highest priority after release); all readies = 0.
REQ-025 Reset asserted mid-transfer SHALL drop the held beat immediately without waiting for a clock; no upstream beat is accepted in that cycle.
REQ-026 First transfer SHALL be possible on the first rising edge after ASYNCRESET deasserts.

Configuration
REQ-027 Macro HANDSHAKE_RR_ARBITER_ASSERT_EN: when defined, embedded concurrent assertions on CLK (disabled during ASYNCRESET) SHALL check: upstream valid and in_k held stable until ready; output stability per REQ-020; readies one-hot-or-zero; out_id != 3.
REQ-028 When the macro is undefined, no assertion or simulation-only code SHALL be compiled; port list and behaviour SHALL be identical.

Verification
REQ-029 Reset release, req0 valid with in_0=4'hA, downstream ready -> edge 1: handshake_valid=1, out=4'hA, out_id=0.
REQ-030 All three valid (in_0=1, in_1=2, in_2=3), ready held 1 for 6 cycles -> out_id sequence 0,1,2,0,1,2, one beat per cycle.
REQ-031 Output valid with out=4'h5, handshake_ready=0 for 4 cycles while req1, req2 valid -> out=4'h5, out_id unchanged, all upstream readies 0; on ready=1 next beat from req1.
REQ-032 Only req2 valid for 3 cycles (in_2=7,8,9), ready=1 -> three beats out_id=2 each; then req0 and req2 valid -> req0 granted next (LG=2).
REQ-033 ASYNCRESET pulsed mid-cycle while handshake_valid=1 and ready=0 -> handshake_valid=0, out=0 before next edge; after release req0 has priority over req1.
REQ-034 With HANDSHAKE_RR_ARBITER_ASSERT_EN defined, req1 drops valid while ready=0 -> stability assertion fires; undefined -> no failure reported.
